ky32_decode: RTL and testbench
==============================

KY32_DECODE -- requirements
Module: ky32_decode

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have fetch-side ports: if_valid in 1, if_ready out 1, if_instr in 32, if_pc in 32.
REQ-005 The block SHALL have register-file read ports: rf_a_addr out 5, rf_b_addr out 5, rf_a_data in 32, rf_b_data in 32 (combinational read, reg 0 reads 0).
REQ-006 The block SHALL have writeback snoop ports: wb_we in 1, wb_addr in 5, wb_data in 32, the same values that write the register file this cycle.
REQ-007 The block SHALL have port flush, input, 1 bit: kills the held decode output.
REQ-008 The block SHALL have execute-side ports: ex_valid out 1, ex_ready in 1, ex_pc out 32, ex_opclass out 4, ex_funct3 out 3, ex_funct7b5 out 1, ex_rd out 5, ex_rs1_val out 32, ex_rs2_val out 32, ex_imm out 32, ex_illegal out 1.

Function
REQ-009 rf_a_addr/rf_b_addr SHALL be if_instr[19:15]/[24:20], driven combinationally every cycle.
REQ-010 Opclass SHALL decode opcode if_instr[6:0]: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, FENCE, SYSTEM; any other opcode or if_instr[1:0]!=2'b11 is ILLEGAL.
REQ-011 ex_imm SHALL be the sign-extended I/S/B/U/J immediate for the opclass; 0 for OP, ILLEGAL.
REQ-012 Operand bypass: if wb_we and wb_addr==rs and rs!=0, operand SHALL be wb_data, else rf data; rs==0 always yields 0.
REQ-013 A 31-entry scoreboard SHALL mark registers with an accepted, uncompleted writer; x0 never busy.
REQ-014 An instruction uses rs1 for all opclasses except LUI, AUIPC, JAL, FENCE, ILLEGAL; rs2 for BRANCH, STORE, OP only.
REQ-015 hazard SHALL assert when a used rs, or the rd of a writing instruction, is busy and not cleared by wb_we/wb_addr this cycle.
REQ-016 if_ready SHALL equal !hazard && (!ex_valid || ex_ready) && !flush.
REQ-017 On if_valid && if_ready the output register SHALL load all ex_* fields next cycle with ex_valid=1; latency 1 cycle.
REQ-018 On acceptance with rd!=0 and opclass in {LUI,AUIPC,JAL,JALR,LOAD,OPIMM,OP}, the rd busy bit SHALL set; same-cycle clear and set of one address: set wins.
REQ-019 wb_we with wb_addr!=0 SHALL clear that busy bit; clear of a non-busy bit is harmless.
REQ-020 ILLEGAL instructions SHALL pass with ex_illegal=1, ex_rd=0, no scoreboard set.
REQ-021 ex_valid && !ex_ready SHALL hold all ex_* stable.
REQ-022 flush SHALL clear ex_valid next cycle and clear the busy bit of ex_rd if ex_valid; no instruction is accepted that cycle.

Reset
REQ-023 On rst high at a clk edge: ex_valid=0, all ex_* fields 0, scoreboard all clear; if_ready low while rst high.
REQ-024 rst SHALL override flush, acceptance and wb clears in the same cycle.

Structure
REQ-025 Opclass enum, opcode constants, and immediate-format enum SHALL reside in shared package ky32_pkg.
REQ-026 A sub-module ky32_scoreboard (set, clear, two reads plus rd read, flush clear) is natural; decoder and output register stay in ky32_decode.

Verification
REQ-027 ADDI x5,x0,7 (0x00700293) accepted -> next cycle ex_valid=1, ex_opclass=OPIMM, ex_rd=5, ex_imm=7, x5 busy.
REQ-028 ADD x6,x5,x5 following while x5 busy -> if_ready=0 until wb_we=1,wb_addr=5,wb_data=7; that cycle accepted with rs1_val=rs2_val=7.
REQ-029 ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* unchanged, if_ready=0; release -> next instruction accepted same cycle.
REQ-030 Instruction 0xFFFFFFFF -> ex_illegal=1, ex_rd=0, scoreboard unchanged.
REQ-031 flush with ex_valid=1, ex_rd=9 -> ex_valid=0 next cycle, x9 not busy, if_ready=0 during flush.
REQ-032 rst asserted mid-stall with x5,x6 busy -> next cycle ex_valid=0, all busy clear, subsequent ADD x6,x5,x5 accepted without stall.

Source files
------------

// File: rtl/ky32_pkg.sv
// Shared decode types for the ky32 front end: opclasses, major opcodes,
// immediate formats and the record held in the decode output register.
package ky32_pkg;

  localparam int REG_AW = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic [3:0] {
    OC_LUI     = 4'd0,
    OC_AUIPC   = 4'd1,
    OC_JAL     = 4'd2,
    OC_JALR    = 4'd3,
    OC_BRANCH  = 4'd4,
    OC_LOAD    = 4'd5,
    OC_STORE   = 4'd6,
    OC_OPIMM   = 4'd7,
    OC_OP      = 4'd8,
    OC_FENCE   = 4'd9,
    OC_SYSTEM  = 4'd10,
    OC_ILLEGAL = 4'd11
  } opclass_t;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0] pc;
    opclass_t    opclass;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic        illegal;
    logic        writes;
  } dec_t;

  function automatic logic uses_rs1(input opclass_t oc);
    return !(oc inside {OC_LUI, OC_AUIPC, OC_JAL, OC_FENCE, OC_ILLEGAL});
  endfunction

  function automatic logic uses_rs2(input opclass_t oc);
    return oc inside {OC_BRANCH, OC_STORE, OC_OP};
  endfunction

  function automatic logic writes_rd(input opclass_t oc);
    return oc inside {OC_LUI, OC_AUIPC, OC_JAL, OC_JALR, OC_LOAD, OC_OPIMM, OC_OP};
  endfunction

endpackage

// File: rtl/ky32_scoreboard.sv
// Busy bit per architectural register marking an accepted writer that has
// not written back yet. x0 is never busy.
module ky32_scoreboard
  import ky32_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic              flush_en,
  input  logic [REG_AW-1:0] flush_addr,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [REG_AW-1:0] rd_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rd_busy
);

  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;

  assign busy_next[0] = 1'b0;

  // A set of the same register in the cycle its old writer completes wins.
  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_bit
    assign busy_next[gi] =
      (set_en && set_addr == REG_AW'(gi)) ? 1'b1 :
      ((clr_en && clr_addr == REG_AW'(gi)) ||
       (flush_en && flush_addr == REG_AW'(gi))) ? 1'b0 : busy_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) busy_reg <= '0;
    else     busy_reg <= busy_next;
  end

  assign rs1_busy = busy_reg[rs1_addr];
  assign rs2_busy = busy_reg[rs2_addr];
  assign rd_busy  = busy_reg[rd_addr];

endmodule

// File: rtl/ky32_decode.sv
// Decode stage: classifies the fetched instruction, reads and bypasses
// operands, stalls on scoreboard hazards and holds one decoded record.
module ky32_decode
  import ky32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rf_a_addr,
  output logic [4:0]      rf_b_addr,
  input  logic [XLEN-1:0] rf_a_data,
  input  logic [XLEN-1:0] rf_b_data,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [3:0]      ex_opclass,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic            ex_illegal
);

  opclass_t    opclass;
  imm_fmt_t    imm_fmt;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;
  logic        rs1_busy, rs2_busy, rd_busy;
  logic        hazard, accept, dec_writes;
  dec_t        dec;
  dec_t        ex_reg;
  logic        ex_valid_reg;

  assign rs1 = if_instr[19:15];
  assign rs2 = if_instr[24:20];
  assign rf_a_addr = rs1;
  assign rf_b_addr = rs2;

  always_comb begin
    opclass = OC_ILLEGAL;
    if (if_instr[1:0] == 2'b11) begin
      case (if_instr[6:0])
        OPC_LUI:    opclass = OC_LUI;
        OPC_AUIPC:  opclass = OC_AUIPC;
        OPC_JAL:    opclass = OC_JAL;
        OPC_JALR:   opclass = OC_JALR;
        OPC_BRANCH: opclass = OC_BRANCH;
        OPC_LOAD:   opclass = OC_LOAD;
        OPC_STORE:  opclass = OC_STORE;
        OPC_OPIMM:  opclass = OC_OPIMM;
        OPC_OP:     opclass = OC_OP;
        OPC_FENCE:  opclass = OC_FENCE;
        OPC_SYSTEM: opclass = OC_SYSTEM;
        default:    opclass = OC_ILLEGAL;
      endcase
    end
  end

  always_comb begin
    imm_fmt = IMM_NONE;
    case (opclass)
      OC_LUI, OC_AUIPC:                           imm_fmt = IMM_U;
      OC_JAL:                                     imm_fmt = IMM_J;
      OC_JALR, OC_LOAD, OC_OPIMM, OC_FENCE, OC_SYSTEM: imm_fmt = IMM_I;
      OC_BRANCH:                                  imm_fmt = IMM_B;
      OC_STORE:                                   imm_fmt = IMM_S;
      default:                                    imm_fmt = IMM_NONE;
    endcase
  end

  always_comb begin
    imm = '0;
    case (imm_fmt)
      IMM_I: imm = {{20{if_instr[31]}}, if_instr[31:20]};
      IMM_S: imm = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      IMM_B: imm = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                    if_instr[30:25], if_instr[11:8], 1'b0};
      IMM_U: imm = {if_instr[31:12], 12'b0};
      IMM_J: imm = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                    if_instr[20], if_instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  assign rd = (opclass == OC_ILLEGAL) ? 5'd0 : if_instr[11:7];
  assign dec_writes = writes_rd(opclass) && (rd != 5'd0);

  // A writeback landing this cycle both forwards its data and retires the busy bit.
  always_comb begin
    dec          = '0;
    dec.pc       = if_pc;
    dec.opclass  = opclass;
    dec.funct3   = if_instr[14:12];
    dec.funct7b5 = if_instr[30];
    dec.rd       = rd;
    dec.imm      = imm;
    dec.illegal  = (opclass == OC_ILLEGAL);
    dec.writes   = dec_writes;
    if (rs1 == 5'd0)                     dec.rs1_val = '0;
    else if (wb_we && wb_addr == rs1)    dec.rs1_val = wb_data;
    else                                 dec.rs1_val = rf_a_data;
    if (rs2 == 5'd0)                     dec.rs2_val = '0;
    else if (wb_we && wb_addr == rs2)    dec.rs2_val = wb_data;
    else                                 dec.rs2_val = rf_b_data;
  end

  assign hazard = (uses_rs1(opclass) && rs1_busy && !(wb_we && wb_addr == rs1)) ||
                  (uses_rs2(opclass) && rs2_busy && !(wb_we && wb_addr == rs2)) ||
                  (dec_writes && rd_busy && !(wb_we && wb_addr == rd));

  assign if_ready = !rst && !hazard && (!ex_valid_reg || ex_ready) && !flush;
  assign accept   = if_valid && if_ready;

  ky32_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en     (accept && dec_writes),
    .set_addr   (rd),
    .clr_en     (wb_we),
    .clr_addr   (wb_addr),
    .flush_en   (flush && ex_valid_reg && ex_reg.writes),
    .flush_addr (ex_reg.rd),
    .rs1_addr   (rs1),
    .rs2_addr   (rs2),
    .rd_addr    (rd),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .rd_busy    (rd_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_reg <= 1'b0;
      ex_reg       <= '0;
    end else if (flush) begin
      ex_valid_reg <= 1'b0;
    end else if (accept) begin
      ex_valid_reg <= 1'b1;
      ex_reg       <= dec;
    end else if (ex_ready) begin
      ex_valid_reg <= 1'b0;
    end
  end

  assign ex_valid    = ex_valid_reg;
  assign ex_pc       = ex_reg.pc;
  assign ex_opclass  = ex_reg.opclass;
  assign ex_funct3   = ex_reg.funct3;
  assign ex_funct7b5 = ex_reg.funct7b5;
  assign ex_rd       = ex_reg.rd;
  assign ex_rs1_val  = ex_reg.rs1_val;
  assign ex_rs2_val  = ex_reg.rs2_val;
  assign ex_imm      = ex_reg.imm;
  assign ex_illegal  = ex_reg.illegal;

endmodule

// File: tb/tb_ky32_decode.sv
// Directed bench for ky32_decode: decode vector table plus hand-written
// stall, backpressure, flush, illegal and reset sequences.
module tb_ky32_decode;
  import ky32_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] if_instr = 32'h0000_0013;
  logic [31:0] if_pc = 32'h0;
  logic [4:0]  rf_a_addr, rf_b_addr;
  logic [31:0] rf_a_data, rf_b_data;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'h0;
  logic        flush = 1'b0;
  logic        ex_valid;
  logic        ex_ready = 1'b1;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [3:0]  ex_opclass;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5, ex_illegal;
  logic [4:0]  ex_rd;

  logic [31:0] rf_mem [32];
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ky32_decode #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rf_a_addr(rf_a_addr), .rf_b_addr(rf_b_addr), .rf_a_data(rf_a_data), .rf_b_data(rf_b_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_opclass(ex_opclass),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_rd(ex_rd),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_illegal(ex_illegal)
  );

  // Register file model: combinational read, x0 reads zero, written by writeback.
  assign rf_a_data = (rf_a_addr == 5'd0) ? 32'h0 : rf_mem[rf_a_addr];
  assign rf_b_data = (rf_b_addr == 5'd0) ? 32'h0 : rf_mem[rf_b_addr];
  always @(posedge clk) if (wb_we && wb_addr != 5'd0) rf_mem[wb_addr] <= wb_data;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  opclass;
    logic [2:0]  f3;
    logic        f7b5;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ill;
    logic        chk_ops;
    logic [31:0] rs1v;
    logic [31:0] rs2v;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction, wait (bounded) for acceptance, then drop if_valid.
  task automatic apply(input logic [31:0] instr, input logic [31:0] pc, input string name);
    int n;
    if_instr = instr;
    if_pc    = pc;
    if_valid = 1'b1;
    #1;
    n = 0;
    while (!if_ready && n < 10) begin
      tick();
      n++;
    end
    if (!if_ready) chk({name, "_accept_timeout"}, 0, 1);
    tick();
    if_valid = 1'b0;
  endtask

  task automatic wb_clear(input logic [4:0] a);
    wb_we   = 1'b1;
    wb_addr = a;
    wb_data = rf_mem[a];
    tick();
    wb_we   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h100 + i;

    vecs[0]  = '{32'h0070_0293, OC_OPIMM,   3'd0, 1'b0, 5'd5,  32'h0000_0007, 1'b0, 1'b0, 0, 0};
    vecs[1]  = '{32'h1234_50B7, OC_LUI,     3'd5, 1'b0, 5'd1,  32'h1234_5000, 1'b0, 1'b0, 0, 0};
    vecs[2]  = '{32'hFFFF_F117, OC_AUIPC,   3'd7, 1'b1, 5'd2,  32'hFFFF_F000, 1'b0, 1'b0, 0, 0};
    vecs[3]  = '{32'hFFDF_F0EF, OC_JAL,     3'd7, 1'b1, 5'd1,  32'hFFFF_FFFC, 1'b0, 1'b0, 0, 0};
    vecs[4]  = '{32'hFFF0_01E7, OC_JALR,    3'd0, 1'b1, 5'd3,  32'hFFFF_FFFF, 1'b0, 1'b0, 0, 0};
    vecs[5]  = '{32'h0000_0463, OC_BRANCH,  3'd0, 1'b0, 5'd8,  32'h0000_0008, 1'b0, 1'b0, 0, 0};
    vecs[6]  = '{32'hFE00_2E23, OC_STORE,   3'd2, 1'b1, 5'd28, 32'hFFFF_FFFC, 1'b0, 1'b0, 0, 0};
    vecs[7]  = '{32'h0100_2383, OC_LOAD,    3'd2, 1'b0, 5'd7,  32'h0000_0010, 1'b0, 1'b0, 0, 0};
    vecs[8]  = '{32'h4000_0433, OC_OP,      3'd0, 1'b1, 5'd8,  32'h0000_0000, 1'b0, 1'b0, 0, 0};
    vecs[9]  = '{32'h0FF0_000F, OC_FENCE,   3'd0, 1'b0, 5'd0,  32'h0000_00FF, 1'b0, 1'b0, 0, 0};
    vecs[10] = '{32'h0010_0073, OC_SYSTEM,  3'd0, 1'b0, 5'd0,  32'h0000_0001, 1'b0, 1'b0, 0, 0};
    vecs[11] = '{32'h00C5_8533, OC_OP,      3'd0, 1'b0, 5'd10, 32'h0000_0000, 1'b0, 1'b1, 32'h10B, 32'h10C};
    vecs[12] = '{32'hFFFF_FFFF, OC_ILLEGAL, 3'd7, 1'b1, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 0, 0};
    vecs[13] = '{32'h0000_0010, OC_ILLEGAL, 3'd0, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 0, 0};
    vecs[14] = '{32'h0000_007F, OC_ILLEGAL, 3'd0, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 0, 0};

    // Reset state.
    if_valid = 1'b1;
    tick();
    tick();
    chk("rst_if_ready", if_ready, 0);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_fields", {ex_pc, ex_imm, ex_rd, ex_opclass}, 0);
    if_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Decode table.
    for (int i = 0; i < 15; i++) begin
      apply(vecs[i].instr, 32'h1000 + 4 * i, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_valid", i), ex_valid, 1);
      chk($sformatf("vec%0d_pc", i), ex_pc, 32'h1000 + 4 * i);
      chk($sformatf("vec%0d_fields", i),
          {ex_opclass, ex_funct3, ex_funct7b5, ex_rd, ex_imm, ex_illegal},
          {vecs[i].opclass, vecs[i].f3, vecs[i].f7b5, vecs[i].rd, vecs[i].imm, vecs[i].ill});
      if (vecs[i].chk_ops)
        chk($sformatf("vec%0d_ops", i), {ex_rs1_val, ex_rs2_val}, {vecs[i].rs1v, vecs[i].rs2v});
      wb_clear(vecs[i].rd);
    end

    // RAW stall on x5, released by the writeback with forwarding.
    apply(32'h0070_0293, 32'h2000, "addi_x5");
    chk("addi_x5_fields", {ex_valid, ex_opclass, ex_rd, ex_imm}, {1'b1, OC_OPIMM, 5'd5, 32'd7});
    if_instr = 32'h0052_8333;
    if_pc    = 32'h2004;
    if_valid = 1'b1;
    #1;
    chk("raw_stall0", if_ready, 0);
    tick();
    chk("raw_stall1", {if_ready, ex_valid}, 2'b00);
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'd7;
    #1;
    chk("raw_release", if_ready, 1);
    tick();
    wb_we = 1'b0;
    chk("raw_fwd_ops", {ex_valid, ex_rd, ex_rs1_val, ex_rs2_val}, {1'b1, 5'd6, 32'd7, 32'd7});

    // Backpressure: three held cycles, then acceptance on release.
    ex_ready = 1'b0;
    if_instr = 32'h0030_0393;
    if_pc    = 32'h2008;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("hold%0d", i), {if_ready, ex_valid, ex_pc, ex_rd, ex_rs1_val},
          {1'b0, 1'b1, 32'h2004, 5'd6, 32'd7});
      tick();
    end
    ex_ready = 1'b1;
    #1;
    chk("release_ready", if_ready, 1);
    tick();
    if_valid = 1'b0;
    chk("release_accept", {ex_pc, ex_rd, ex_imm}, {32'h2008, 5'd7, 32'd3});
    wb_clear(5'd6);
    wb_clear(5'd7);

    // Flush kills the held x9 writer and its busy bit.
    apply(32'h0010_0493, 32'h200C, "addi_x9");
    chk("x9_held", {ex_valid, ex_rd}, {1'b1, 5'd9});
    flush    = 1'b1;
    if_instr = 32'h0020_0513;
    if_pc    = 32'h2010;
    if_valid = 1'b1;
    #1;
    chk("flush_ready", if_ready, 0);
    tick();
    flush = 1'b0;
    chk("flush_valid", ex_valid, 0);
    if_instr = 32'h0004_8613;
    if_pc    = 32'h2014;
    #1;
    chk("x9_not_busy", if_ready, 1);
    tick();
    if_valid = 1'b0;
    chk("post_flush_accept", {ex_valid, ex_rd, ex_pc}, {1'b1, 5'd12, 32'h2014});
    wb_clear(5'd12);

    // Illegal instruction leaves the scoreboard alone (rd field 31).
    apply(32'hFFFF_FFFF, 32'h2018, "illegal");
    chk("illegal_out", {ex_illegal, ex_rd}, {1'b1, 5'd0});
    if_instr = 32'h000F_8093;
    if_pc    = 32'h201C;
    if_valid = 1'b1;
    #1;
    chk("illegal_no_set", if_ready, 1);
    tick();
    if_valid = 1'b0;
    wb_clear(5'd1);

    // Reset mid-stall with x5 and x6 busy.
    apply(32'h0070_0293, 32'h2020, "rst_x5");
    apply(32'h0010_0313, 32'h2024, "rst_x6");
    ex_ready = 1'b0;
    if_instr = 32'h0052_8333;
    if_pc    = 32'h2028;
    if_valid = 1'b1;
    #1;
    chk("pre_rst_stall", if_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_cleared", {ex_valid, ex_rd, ex_imm, ex_pc}, 0);
    ex_ready = 1'b1;
    #1;
    chk("post_rst_no_stall", if_ready, 1);
    tick();
    if_valid = 1'b0;
    chk("post_rst_accept", {ex_valid, ex_rd, ex_rs1_val, ex_rs2_val}, {1'b1, 5'd6, 32'd7, 32'd7});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
